// File: rtl/led_breather_pkg.sv
// Shared types and helpers for the breathing-LED PWM driver.
package led_breather_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } phase_t;

  // Largest value representable in a PWM counter/duty of the given width.
  function automatic int unsigned pwm_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_breather_if.sv
// Control/status bundle between a breathing-LED driver and its controller.
interface led_breather_if #(
  parameter int PWM_BITS = 8
) ();
  import led_breather_pkg::*;

  // enable is a level: high runs the breathing cycle, low forces idle/dark.
  // There is no backpressure; period_end is a single-cycle strobe the
  // consumer samples on any cycle, with duty/phase valid in that same cycle.
  logic                enable;
  logic                pwm_out;
  logic [PWM_BITS-1:0] duty;
  phase_t              phase;
  logic                period_end;

  modport master (output enable, input pwm_out, duty, phase, period_end);
  modport slave  (input enable, output pwm_out, duty, phase, period_end);

endinterface

// File: rtl/led_breather_tick_prescaler.sv
// Divides the system clock into a one-cycle tick every PRESCALE cycles.
module led_breather_tick_prescaler #(
  parameter int unsigned PRESCALE = 48
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pre_cnt_q, pre_cnt_d;

  always_comb begin
    pre_cnt_d = pre_cnt_q + CW'(1);
    if (clear || pre_cnt_q == LAST) pre_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_cnt_q <= '0;
    else        pre_cnt_q <= pre_cnt_d;
  end

  // Gated by clear so a divide-by-one prescaler stays silent while idle.
  assign tick = !clear && (pre_cnt_q == LAST);

endmodule

// File: rtl/led_breather.sv
// Breathing-LED PWM driver: duty ramps up, holds, ramps down, holds, repeat.
module led_breather
  import led_breather_pkg::*;
#(
  parameter int unsigned PRESCALE     = 48,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned STEP_PERIODS = 4,
  parameter int unsigned HOLD_STEPS   = 16
) (
  input logic            clk,
  input logic            rst_n,
  led_breather_if.slave  bus
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = PWM_BITS'(pwm_max(PWM_BITS));
  localparam int unsigned SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int unsigned HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

  phase_t              state_q, state_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [SW-1:0]       step_cnt_q, step_cnt_d;
  logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
  logic                pwm_out_q, pwm_out_d;
  logic                period_end_q, period_end_d;
  logic                clear, tick, boundary, step, running;

  // Counters sit at zero while idle so a fresh run always starts aligned.
  assign clear    = !bus.enable || (state_q == IDLE);
  assign boundary = tick && (pwm_cnt_q == DUTY_MAX);
  assign step     = boundary && (step_cnt_q == STEP_LAST);

  led_breather_tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_tick_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      state_d = RAMP_UP;
        RAMP_UP:   if (step && duty_q == DUTY_MAX)      state_d = HOLD_HIGH;
        HOLD_HIGH: if (step && hold_cnt_q == HOLD_LAST) state_d = RAMP_DOWN;
        RAMP_DOWN: if (step && duty_q == '0)            state_d = HOLD_LOW;
        HOLD_LOW:  if (step && hold_cnt_q == HOLD_LAST) state_d = RAMP_UP;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    running        = (state_q != IDLE);
    bus.phase      = state_q;
    bus.duty       = duty_q;
    bus.pwm_out    = pwm_out_q;
    bus.period_end = period_end_q;
  end

  // Duty only moves on a step, which is always a period boundary.
  always_comb begin
    pwm_cnt_d    = pwm_cnt_q;
    duty_d       = duty_q;
    step_cnt_d   = step_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    pwm_out_d    = running && (pwm_cnt_q < duty_q);
    period_end_d = boundary;
    if (clear) begin
      pwm_cnt_d  = '0;
      duty_d     = '0;
      step_cnt_d = '0;
      hold_cnt_d = '0;
    end else begin
      if (tick)     pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
      if (boundary) step_cnt_d = step ? '0 : step_cnt_q + SW'(1);
      if (step) begin
        case (state_q)
          RAMP_UP: begin
            if (duty_q != DUTY_MAX) duty_d = duty_q + PWM_BITS'(1);
            else                    hold_cnt_d = '0;
          end
          HOLD_HIGH, HOLD_LOW: begin
            hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? '0 : hold_cnt_q + HW'(1);
          end
          RAMP_DOWN: begin
            if (duty_q != '0) duty_d = duty_q - PWM_BITS'(1);
            else              hold_cnt_d = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q    <= '0;
      duty_q       <= '0;
      step_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      pwm_out_q    <= 1'b0;
      period_end_q <= 1'b0;
    end else begin
      pwm_cnt_q    <= pwm_cnt_d;
      duty_q       <= duty_d;
      step_cnt_q   <= step_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      pwm_out_q    <= pwm_out_d;
      period_end_q <= period_end_d;
    end
  end

endmodule
